// File: rtl/mem_access_lsu.sv
// MEM-stage load/store unit: req/ack data port, byte lanes, load extension, misalign detect.
// Optional ack watchdog with o_bus_err enabled by defining MEM_ACCESS_ACK_TIMEOUT_EN.
module mem_access_lsu #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_REG  = 5
`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 16
`endif
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_halt,
    input  logic                 i_valid,
    input  logic [NB_REG-1:0]    i_reg2write,
    input  logic [NB_DATA-1:0]   i_result,
    input  logic [1:0]           i_width,
    input  logic                 i_sign_flag,
    input  logic                 i_mem2reg,
    input  logic                 i_memRead,
    input  logic                 i_memWrite,
    input  logic                 i_regWrite,
    input  logic [NB_DATA-1:0]   i_data4Mem,
    output logic                 o_stall,
    output logic [NB_DATA-1:0]   o_reg_read,
    output logic [NB_DATA-1:0]   o_ALUresult,
    output logic [NB_REG-1:0]    o_reg2write,
    output logic                 o_mem2reg,
    output logic                 o_regWrite,
    output logic                 o_misalign,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [NB_DATA/8-1:0] o_mem_be,
    output logic [NB_ADDR-3:0]   o_mem_addr,
    output logic [NB_DATA-1:0]   o_mem_wdata,
`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
    output logic                 o_bus_err,
`endif
    input  logic [NB_DATA-1:0]   i_mem_rdata,
    input  logic                 i_mem_ack
);
    localparam int NB_BE = NB_DATA / 8;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t             state, state_next;
    logic               acc, mis, req, done, rel, grab, abort, tmo_hit;
    logic               pass_en, mis_en, upd;
    logic [1:0]         off;
    logic [NB_BE-1:0]   be;
    logic [NB_DATA-1:0] wdata, ld_ext, ld_val, rd_buf;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;

    assign off = i_result[1:0];
    assign acc = i_valid & (i_memRead | i_memWrite);
    assign mis = acc & ((i_width == 2'b11) | ((i_width == 2'b01) & off[0]) |
                        ((i_width == 2'b10) & (off != 2'b00)));

    always_comb begin
        state_next = state;
        req        = 1'b0;
        done       = 1'b0;
        rel        = 1'b0;
        grab       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (acc && !mis && !i_halt) begin
                req = 1'b1;
                if (i_mem_ack) done = 1'b1;
                else           state_next = WAIT;
            end
            WAIT: begin
                req = 1'b1;
                if (i_mem_ack) begin
                    // the handshake finishes even under halt; data parks in rd_buf
                    if (i_halt) begin
                        grab       = 1'b1;
                        state_next = HOLD;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end else if (tmo_hit && !i_halt) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: if (!i_halt) begin
                rel        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // saturates at the limit so a halt during the last WAIT cycle defers the abort
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  tmo_cnt <= '0;
        else if (state == WAIT && !i_mem_ack) begin
            if (!tmo_hit)                              tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else                                       tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        be    = '1;
        wdata = i_data4Mem;
        case (i_width)
            2'b00: begin
                be    = NB_BE'(1) << off;
                wdata = {4{i_data4Mem[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? NB_BE'(4'b1100) : NB_BE'(4'b0011);
                wdata = {2{i_data4Mem[15:0]}};
            end
            default: ;
        endcase
    end

    // reset gates the request combinationally so an in-flight access drops at once
    assign o_mem_req   = req & i_rst_n;
    assign o_mem_we    = o_mem_req & i_memWrite;
    assign o_mem_be    = o_mem_req ? be : '0;
    assign o_mem_addr  = o_mem_req ? i_result[NB_ADDR-1:2] : '0;
    assign o_mem_wdata = o_mem_we ? wdata : '0;
    assign o_stall     = (o_mem_req & ~i_mem_ack) | (state == HOLD);

    assign lane_b = i_mem_rdata[{off, 3'b000} +: 8];
    assign lane_h = off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        case (i_width)
            2'b00:   ld_ext = i_sign_flag ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            2'b01:   ld_ext = i_sign_flag ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    // stores write back zero load data
    assign ld_val  = i_memRead ? ld_ext : '0;
    assign pass_en = (state == IDLE) & ~acc & ~i_halt;
    assign mis_en  = (state == IDLE) & mis & ~i_halt;
    assign upd     = done | rel | pass_en | mis_en | abort;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_read  <= '0;
            o_ALUresult <= '0;
            o_reg2write <= '0;
            o_mem2reg   <= 1'b0;
            o_regWrite  <= 1'b0;
            o_misalign  <= 1'b0;
            rd_buf      <= '0;
`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
            o_bus_err   <= 1'b0;
`endif
        end else begin
            o_misalign <= 1'b0;
`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
            o_bus_err  <= 1'b0;
`endif
            if (upd) begin
                o_ALUresult <= i_result;
                o_reg2write <= i_reg2write;
                o_mem2reg   <= i_mem2reg;
                o_regWrite  <= i_valid & i_regWrite & ~mis_en & ~abort;
                o_reg_read  <= rel ? rd_buf : (done ? ld_val : '0);
                o_misalign  <= mis_en;
`ifdef MEM_ACCESS_ACK_TIMEOUT_EN
                o_bus_err   <= abort;
`endif
            end
            if (grab) rd_buf <= ld_val;
        end
    end
endmodule
